// File: rtl/bram2hs_cast_if.sv
// Bundle of the producer BRAM port, fill handshake and vector output stream.
// The design drives the slave side; the upstream kernel and downstream consumer use the master side.
interface bram2hs_cast_if #(
  parameter int OUT_SIZE   = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 7
);
  logic [ADDR_WIDTH-1:0] address0;
  logic                  ce0;
  logic                  we0;
  logic [OUT_WIDTH-1:0]  d0;
  logic [OUT_WIDTH-1:0]  q0;
  logic                  in_done;
  logic                  in_ready;
  logic [OUT_WIDTH-1:0]  data_out [OUT_SIZE];
  logic                  data_out_valid;
  logic                  data_out_ready;

  modport master (
    output address0, ce0, we0, d0, in_done, data_out_ready,
    input  q0, in_ready, data_out, data_out_valid
  );

  modport slave (
    input  address0, ce0, we0, d0, in_done, data_out_ready,
    output q0, in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/bram2hs_cast.sv
// RAM-backed cast from a BRAM-style producer port to a valid/ready vector stream.
// The producer fills the RAM and then pulses in_done; the RAM is read back in OUT_SIZE-lane vectors.
module bram2hs_cast #(
  parameter int OUT_SIZE   = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int ADDR_RANGE = 100,
  parameter int ADDR_WIDTH = 7
) (
  input logic            clk,
  input logic            rst,
  bram2hs_cast_if.slave  bus
);

  localparam int LANE_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(OUT_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_RANGE - 1);

  typedef enum logic [1:0] {FILL, LOAD, DRAIN, OUT} state_t;

  state_t                state;
  logic [OUT_WIDTH-1:0]  mem [ADDR_RANGE];
  logic [OUT_WIDTH-1:0]  q0_r;
  logic [OUT_WIDTH-1:0]  rd_data;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [LANE_W-1:0]     lane_cnt;
  logic [LANE_W-1:0]     rd_lane;
  logic                  rd_pend;
  logic                  last_vec;
  logic                  in_ready_r;
  logic                  valid_r;
  logic [OUT_WIDTH-1:0]  buffer [OUT_SIZE];

  // NOTE: the RAM and its read registers carry no reset, so they map onto block RAM;
  // its contents survive a reset and are reused by the next in_done.
  always_ff @(posedge clk) begin
    if (bus.ce0 && bus.we0 && state == FILL)
      mem[bus.address0] <= bus.d0;
    if (bus.ce0)
      q0_r <= mem[bus.address0];
    if (state == LOAD)
      rd_data <= mem[addr_cnt];
  end

  // NOTE: every register here uses <=, so all branches see the pre-edge values of
  // state, lane_cnt and addr_cnt regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FILL;
      addr_cnt   <= '0;
      lane_cnt   <= '0;
      rd_lane    <= '0;
      rd_pend    <= 1'b0;
      last_vec   <= 1'b0;
      in_ready_r <= 1'b1;
      valid_r    <= 1'b0;
      buffer     <= '{default: '0};
    end else begin
      rd_pend <= 1'b0;
      // Word read in the previous cycle lands in the lane it was tagged with.
      if (rd_pend)
        buffer[rd_lane] <= rd_data;

      case (state)
        FILL: begin
          if (bus.in_done) begin
            state      <= LOAD;
            in_ready_r <= 1'b0;
            addr_cnt   <= '0;
            lane_cnt   <= '0;
            last_vec   <= 1'b0;
            buffer     <= '{default: '0};
          end
        end

        LOAD: begin
          rd_lane  <= lane_cnt;
          rd_pend  <= 1'b1;
          addr_cnt <= addr_cnt + 1'b1;
          lane_cnt <= lane_cnt + 1'b1;
          if (lane_cnt == LAST_LANE || addr_cnt == LAST_ADDR) begin
            state    <= DRAIN;
            last_vec <= (addr_cnt == LAST_ADDR);
          end
        end

        DRAIN: begin
          state   <= OUT;
          valid_r <= 1'b1;
        end

        OUT: begin
          if (bus.data_out_ready) begin
            valid_r <= 1'b0;
            if (last_vec) begin
              state      <= FILL;
              in_ready_r <= 1'b1;
            end else begin
              state    <= LOAD;
              lane_cnt <= '0;
              buffer   <= '{default: '0};
            end
          end
        end

        default: state <= FILL;
      endcase
    end
  end

  assign bus.q0             = q0_r;
  assign bus.in_ready       = in_ready_r;
  assign bus.data_out_valid = valid_r;
  assign bus.data_out       = buffer;

endmodule

// File: tb/tb_bram2hs_cast.sv
// Scoreboard bench for bram2hs_cast: stimulus queues expected vectors, a monitor
// compares each vector at its handshake.
module tb_bram2hs_cast;

  localparam int OS = 8;
  localparam int OW = 8;
  localparam int AR = 100;
  localparam int AW = 7;
  localparam int NV = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bram2hs_cast_if #(.OUT_SIZE(OS), .OUT_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

  bram2hs_cast #(.OUT_SIZE(OS), .OUT_WIDTH(OW), .ADDR_RANGE(AR), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc   = 0;
  int                n_hs  = 0;
  logic [OS*OW-1:0]  exp_q[$];
  int                hs_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OS*OW-1:0] pack_out();
    logic [OS*OW-1:0] v;
    for (int i = 0; i < OS; i++) v[i*OW +: OW] = bus.data_out[i];
    return v;
  endfunction

  function automatic logic [OS*OW-1:0] vec_exp(int k);
    logic [OS*OW-1:0] v;
    for (int i = 0; i < OS; i++) begin
      int w;
      w = k * OS + i;
      v[i*OW +: OW] = (w < AR) ? OW'(w) : '0;
    end
    return v;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitor: every accepted vector is compared against the head of the queue.
  always @(negedge clk) begin
    if (rst && bus.data_out_valid && bus.data_out_ready) begin
      n_hs++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_vector: got %h, want none", pack_out());
      end else begin
        check($sformatf("vector_hs%0d", n_hs), pack_out(), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vectors(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(vec_exp(k));
  endtask

  task automatic wait_hs(int target, int budget, string name);
    for (int i = 0; i < budget && n_hs < target; i++) tick();
    check(name, 64'(n_hs), 64'(target));
  endtask

  task automatic wait_valid(int budget, string name);
    for (int i = 0; i < budget && !bus.data_out_valid; i++) tick();
    check(name, 64'(bus.data_out_valid), 64'd1);
  endtask

  task automatic pulse_done(output int t);
    tick();
    bus.in_done = 1'b1;
    t = cyc + 1;
    tick();
    bus.in_done = 1'b0;
  endtask

  initial begin
    int t;
    int base;
    logic [OS*OW-1:0] snap;
    logic stable;

    bus.address0       = '0;
    bus.ce0            = 1'b0;
    bus.we0            = 1'b0;
    bus.d0             = '0;
    bus.in_done        = 1'b0;
    bus.data_out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_valid", 64'(bus.data_out_valid), 64'd0);
    check("rst_data", 64'(pack_out()), 64'd0);
    tick();
    rst = 1'b1;

    // Fill RAM[a]=a; the last write shares its edge with in_done
    push_vectors(NV);
    for (int a = 0; a < AR; a++) begin
      tick();
      bus.ce0      = 1'b1;
      bus.we0      = 1'b1;
      bus.address0 = AW'(a);
      bus.d0       = OW'(a);
      bus.in_done  = (a == AR - 1);
      if (a == AR - 1) t = cyc + 1;
    end
    tick();
    bus.ce0     = 1'b0;
    bus.we0     = 1'b0;
    bus.in_done = 1'b0;
    wait_hs(NV, 400, "fill1_all_vectors");
    check("fill1_in_ready", 64'(bus.in_ready), 64'd1);
    check("fill1_queue_empty", 64'(exp_q.size()), 64'd0);
    if (hs_cyc.size() >= NV) begin
      check("latency_first_valid", 64'(hs_cyc[0] - t), 64'd9);
      check("spacing_v0_v1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd10);
      check("spacing_v10_v11", 64'(hs_cyc[11] - hs_cyc[10]), 64'd10);
    end else begin
      check("latency_handshakes_seen", 64'(hs_cyc.size()), 64'(NV));
    end

    // Protected RAM, q0 readback, stray in_done in LOAD, backpressure, stray in_done in OUT
    base = n_hs;
    push_vectors(NV);
    pulse_done(t);
    bus.ce0      = 1'b1;
    bus.we0      = 1'b1;
    bus.address0 = AW'(5);
    bus.d0       = 8'hFF;
    bus.in_done  = 1'b1;
    check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.we0      = 1'b0;
    bus.address0 = AW'(7);
    bus.in_done  = 1'b0;
    tick();
    bus.ce0 = 1'b0;
    check("q0_read_7", 64'(bus.q0), 64'd7);

    wait_hs(base + 3, 200, "bp_reach_vector3");
    bus.data_out_ready = 1'b0;
    wait_valid(50, "bp_valid_rises");
    bus.in_done = 1'b1;
    tick();
    bus.in_done = 1'b0;
    snap   = pack_out();
    stable = 1'b1;
    check("bp_vector3", 64'(snap), 64'(vec_exp(3)));
    repeat (20) begin
      tick();
      if (!bus.data_out_valid || pack_out() !== snap) stable = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_no_advance", 64'(n_hs), 64'(base + 3));
    bus.data_out_ready = 1'b1;
    wait_hs(base + NV, 300, "fill2_all_vectors");
    check("fill2_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset while vector 6 is waiting in OUT, then restart from the retained RAM
    base = n_hs;
    push_vectors(6);
    pulse_done(t);
    wait_hs(base + 6, 200, "rst_reach_vector6");
    bus.data_out_ready = 1'b0;
    wait_valid(50, "rst_valid_v6");
    check("rst_v6_data", 64'(pack_out()), 64'(vec_exp(6)));
    rst = 1'b0;
    tick();
    check("midrst_valid", 64'(bus.data_out_valid), 64'd0);
    check("midrst_data", 64'(pack_out()), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;
    bus.data_out_ready = 1'b1;
    check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
    base = n_hs;
    push_vectors(NV);
    pulse_done(t);
    wait_hs(base + NV, 300, "restart_all_vectors");
    check("restart_in_ready", 64'(bus.in_ready), 64'd1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
